// File: rtl/clock_pkg.sv
// Shared types and limits for the clock/alarm display path.
//   disp_state_t : display-mode controller states
//   time_bcd_t   : packed BCD time {Ht[1:0], Ho[3:0], Mt[3:0], Mo[3:0]}
//   MAX_HR       : last legal hour value before wrap to 00
//   MAX_MIN      : last legal minute value before wrap to 00
package clock_pkg;

  typedef enum logic [1:0] {
    CLOCK      = 2'd0,
    VIEW_ALARM = 2'd1,
    SET_HR     = 2'd2,
    SET_MIN    = 2'd3
  } disp_state_t;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] ho;
    logic [3:0] mt;
    logic [3:0] mo;
  } time_bcd_t;

  localparam int unsigned MAX_HR  = 23;
  localparam int unsigned MAX_MIN = 59;

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational two-digit BCD +1 with a programmable wrap value.
// Any illegal input (non-BCD digit or value above WRAP) yields 00, as does WRAP itself.
// Ports:
//   tens     in  TENS_W  tens digit
//   ones     in  4       ones digit
//   tens_nxt out TENS_W  incremented tens digit
//   ones_nxt out 4       incremented ones digit
module bcd_field_inc #(
  parameter int unsigned WRAP   = 23,
  parameter int unsigned TENS_W = 4
) (
  input  logic [TENS_W-1:0] tens,
  input  logic [3:0]        ones,
  output logic [TENS_W-1:0] tens_nxt,
  output logic [3:0]        ones_nxt
);

  logic [7:0] tens_ext;
  logic [7:0] value;
  logic       legal;

  assign tens_ext = {{(8-TENS_W){1'b0}}, tens};
  assign value    = (tens_ext * 8'd10) + {4'd0, ones};
  assign legal    = (ones <= 4'd9) && (tens_ext <= 8'd9) && (value <= 8'(WRAP));

  // Increment with decimal carry from ones into tens; wrap or illegal input clears to 00.
  always_comb begin
    tens_nxt = '0;
    ones_nxt = 4'd0;
    if (!legal || (value == 8'(WRAP))) begin
      tens_nxt = '0;
      ones_nxt = 4'd0;
    end else if (ones == 4'd9) begin
      tens_nxt = tens + {{(TENS_W-1){1'b0}}, 1'b1};
      ones_nxt = 4'd0;
    end else begin
      tens_nxt = tens;
      ones_nxt = ones + 4'd1;
    end
  end

endmodule

// File: rtl/display_mode_ctrl.sv
// Display-mode controller for the clock/alarm time mux.
// Steps CLOCK -> VIEW_ALARM -> SET_HR -> SET_MIN -> CLOCK on mode_pulse, edits the alarm
// hours/minutes on inc_pulse, and falls back to CLOCK after TIMEOUT_SEC idle seconds.
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   asynchronous active-low reset
//   mode_pulse  in  1   debounced MODE button pulse
//   inc_pulse   in  1   debounced INC button pulse
//   tick_1hz    in  1   once-per-second pulse, timeout time base
//   sel         out 1   mux select, 0 = clock time, 1 = alarm time
//   alarm_Time  out 14  alarm time, packed BCD
//   blink_hr    out 1   hours field under edit
//   blink_min   out 1   minutes field under edit
//   alarm_dirty out 1   one-cycle pulse when an edit session ends with the alarm changed
module display_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [13:0] ALARM_RST   = 14'h0600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_pulse,
  input  logic        inc_pulse,
  input  logic        tick_1hz,
  output logic        sel,
  output logic [13:0] alarm_Time,
  output logic        blink_hr,
  output logic        blink_min,
  output logic        alarm_dirty
);

  disp_state_t state;
  disp_state_t state_nxt;
  time_bcd_t   alarm;
  time_bcd_t   alarm_nxt;
  time_bcd_t   snapshot;
  logic [5:0]  idle_cnt;
  logic [5:0]  idle_cnt_nxt;
  logic        button;
  logic        timeout;
  logic        dirty_nxt;
  logic [1:0]  hr_tens_inc;
  logic [3:0]  hr_ones_inc;
  logic [3:0]  min_tens_inc;
  logic [3:0]  min_ones_inc;

  bcd_field_inc #(.WRAP(MAX_HR), .TENS_W(2)) u_hr_inc (
    .tens     (alarm.ht),
    .ones     (alarm.ho),
    .tens_nxt (hr_tens_inc),
    .ones_nxt (hr_ones_inc)
  );

  bcd_field_inc #(.WRAP(MAX_MIN), .TENS_W(4)) u_min_inc (
    .tens     (alarm.mt),
    .ones     (alarm.mo),
    .tens_nxt (min_tens_inc),
    .ones_nxt (min_ones_inc)
  );

  // Any button press counts as activity and masks a coincident timeout tick.
  assign button  = mode_pulse | inc_pulse;
  assign timeout = (state != CLOCK) && !button && tick_1hz &&
                   (idle_cnt == 6'(TIMEOUT_SEC - 1));

  // Next state, alarm edit, idle counter and dirty compare.
  always_comb begin
    state_nxt    = state;
    alarm_nxt    = alarm;
    idle_cnt_nxt = idle_cnt;
    dirty_nxt    = 1'b0;

    if (mode_pulse) begin
      case (state)
        CLOCK:      state_nxt = VIEW_ALARM;
        VIEW_ALARM: state_nxt = SET_HR;
        SET_HR:     state_nxt = SET_MIN;
        SET_MIN:    state_nxt = CLOCK;
        default:    state_nxt = CLOCK;
      endcase
    end else if (timeout) begin
      state_nxt = CLOCK;
    end else begin
      state_nxt = state;
    end

    // mode_pulse takes priority, so an inc in the same cycle is dropped.
    if (inc_pulse && !mode_pulse) begin
      case (state)
        SET_HR: begin
          alarm_nxt.ht = hr_tens_inc;
          alarm_nxt.ho = hr_ones_inc;
        end
        SET_MIN: begin
          alarm_nxt.mt = min_tens_inc;
          alarm_nxt.mo = min_ones_inc;
        end
        default: alarm_nxt = alarm;
      endcase
    end else begin
      alarm_nxt = alarm;
    end

    if (button || (state_nxt == CLOCK)) begin
      idle_cnt_nxt = 6'd0;
    end else if (tick_1hz) begin
      idle_cnt_nxt = idle_cnt + 6'd1;
    end else begin
      idle_cnt_nxt = idle_cnt;
    end

    // Session ends leaving SET_MIN (mode or timeout) or on timeout out of SET_HR.
    if (((state == SET_MIN) && (state_nxt == CLOCK)) || ((state == SET_HR) && timeout)) begin
      dirty_nxt = (alarm_nxt != snapshot);
    end else begin
      dirty_nxt = 1'b0;
    end
  end

  // State, alarm, idle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLOCK;
      alarm       <= time_bcd_t'(ALARM_RST);
      idle_cnt    <= 6'd0;
      sel         <= 1'b0;
      blink_hr    <= 1'b0;
      blink_min   <= 1'b0;
      alarm_dirty <= 1'b0;
    end else begin
      state       <= state_nxt;
      alarm       <= alarm_nxt;
      idle_cnt    <= idle_cnt_nxt;
      sel         <= (state_nxt != CLOCK);
      blink_hr    <= (state_nxt == SET_HR);
      blink_min   <= (state_nxt == SET_MIN);
      alarm_dirty <= dirty_nxt;
    end
  end

  // Snapshot of the alarm taken on entry to SET_HR, reference for the dirty compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= time_bcd_t'(ALARM_RST);
    end else if ((state != SET_HR) && (state_nxt == SET_HR)) begin
      snapshot <= alarm;
    end else begin
      snapshot <= snapshot;
    end
  end

  assign alarm_Time = alarm;

endmodule
